// File: rtl/usb_rx_pkt_fifo_if.sv
// usb_rx_pkt_fifo_if: packet write side, read side and status bundle
// for the USB RX packet FIFO.
interface usb_rx_pkt_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 9,
  parameter int CNTW  = 8
);
  logic             wr_en;
  logic [DSIZE-1:0] wr_data;
  logic             pkt_commit;
  logic             pkt_drop;
  logic             rd_en;
  logic [DSIZE-1:0] rd_data;
  logic             rd_valid;
  logic [ASIZE:0]   level;
  logic [ASIZE:0]   free;
  logic             full;
  logic             empty;
  logic             busy;
  logic [CNTW-1:0]  drop_cnt;

  modport master (
    output wr_en, wr_data, pkt_commit, pkt_drop, rd_en,
    input  rd_data, rd_valid, level, free,
    input  full, empty, busy, drop_cnt
  );

  modport slave (
    input  wr_en, wr_data, pkt_commit, pkt_drop, rd_en,
    output rd_data, rd_valid, level, free,
    output full, empty, busy, drop_cnt
  );
endinterface

// File: rtl/usb_rx_pkt_fifo.sv
// usb_rx_pkt_fifo: commit/drop packet FIFO for USB RX data.
// Define RXPKT_OVF_DROP_EN to discard packets that overflow.
module usb_rx_pkt_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 9,
  parameter int CNTW  = 8
) (
  input logic CLK,
  input logic RSTn,
  usb_rx_pkt_fifo_if.slave bus
);

  localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};

`ifdef RXPKT_OVF_DROP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVF  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_t;
`endif

  state_t           state;
  logic             busy_q;
  logic [ASIZE:0]   wp;
  logic [ASIZE:0]   cp;
  logic [ASIZE:0]   rp;
  logic [ASIZE:0]   wp_inc;
  logic [ASIZE:0]   level_q;
  logic [ASIZE:0]   free_q;
  logic [CNTW-1:0]  drop_q;
  logic [CNTW-1:0]  drop_nx;
  logic [DSIZE-1:0] rd_q;
  logic             rdv_q;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  logic [DSIZE-1:0] ram [2**ASIZE];

  assign full = (wp[ASIZE] != rp[ASIZE]) &&
                (wp[ASIZE-1:0] == rp[ASIZE-1:0]);
  assign empty = (cp == rp);

`ifdef RXPKT_OVF_DROP_EN
  logic ovf_try;
  assign ovf_try = bus.wr_en & full;
  assign wr_acc  = bus.wr_en & ~full & (state != OVF);
`else
  assign wr_acc  = bus.wr_en & ~full;
`endif

  assign rd_acc  = bus.rd_en & ~empty;
  assign wp_inc  = wp + {{ASIZE{1'b0}}, wr_acc};
  assign drop_nx = drop_q + {{(CNTW-1){1'b0}}, ~&drop_q};

  always_ff @(posedge CLK) begin
    if (wr_acc)
      ram[wp[ASIZE-1:0]] <= bus.wr_data;
  end

  // Writer FSM: wp runs ahead, cp only moves on a good packet.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      wp     <= '0;
      cp     <= '0;
      drop_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_acc) begin
            wp     <= wp_inc;
            state  <= RECV;
            busy_q <= 1'b1;
          end
        end
        RECV: begin
          if (bus.pkt_drop) begin
            wp     <= cp;
            drop_q <= drop_nx;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.pkt_commit) begin
            wp     <= wp_inc;
            cp     <= wp_inc;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            wp <= wp_inc;
`ifdef RXPKT_OVF_DROP_EN
            if (ovf_try) state <= OVF;
`endif
          end
        end
`ifdef RXPKT_OVF_DROP_EN
        OVF: begin
          if (bus.pkt_drop | bus.pkt_commit) begin
            wp     <= cp;
            drop_q <= drop_nx;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rp      <= '0;
      rd_q    <= '0;
      rdv_q   <= 1'b0;
      level_q <= '0;
      free_q  <= DEPTH;
    end else begin
      rdv_q   <= rd_acc;
      level_q <= cp - rp;
      free_q  <= DEPTH - (wp - rp);
      if (rd_acc) begin
        rd_q <= ram[rp[ASIZE-1:0]];
        rp   <= rp + 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rdv_q;
  assign bus.level    = level_q;
  assign bus.free     = free_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_usb_rx_pkt_fifo.sv
// tb_usb_rx_pkt_fifo: vector table plus scoreboard bench for the
// RX packet FIFO (16-deep instance modelled, default instance spot-checked).
module tb_usb_rx_pkt_fifo;

`ifdef RXPKT_OVF_DROP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic CLK;
  logic RSTn;

  usb_rx_pkt_fifo_if #(.DSIZE(8), .ASIZE(4), .CNTW(8)) ia ();
  usb_rx_pkt_fifo_if #(.DSIZE(8), .ASIZE(9), .CNTW(8)) ib ();

  usb_rx_pkt_fifo #(.DSIZE(8), .ASIZE(4), .CNTW(8)) dut_a (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (ia.slave)
  );

  usb_rx_pkt_fifo #(.DSIZE(8), .ASIZE(9), .CNTW(8)) dut_b (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (ib.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  logic [7:0] q_comm[$];
  logic [7:0] pend[$];
  logic [7:0] exp_rd[$];
  int mst;
  int drops;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       cm;
    logic       dr;
    logic       re;
    logic       e_empty;
    int         e_level;
    logic       e_rdv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic we, input logic [7:0] wd,
                       input logic cm, input logic dr, input logic re);
    ia.wr_en = we; ia.wr_data = wd; ia.pkt_commit = cm;
    ia.pkt_drop = dr; ia.rd_en = re;
    ib.wr_en = we; ib.wr_data = wd; ib.pkt_commit = cm;
    ib.pkt_drop = dr; ib.rd_en = re;
  endtask

  task automatic chk_rst();
    chk("rst_rdv_a", ia.rd_valid, 0);
    chk("rst_rd_a", ia.rd_data, 0);
    chk("rst_level_a", ia.level, 0);
    chk("rst_free_a", ia.free, 16);
    chk("rst_free_b", ib.free, 512);
    chk("rst_drop_a", ia.drop_cnt, 0);
    chk("rst_empty_a", ia.empty, 1);
    chk("rst_full_a", ia.full, 0);
    chk("rst_busy_a", ia.busy, 0);
    chk("rst_empty_b", ib.empty, 1);
  endtask

  task automatic do_reset(input bit check);
    q_comm.delete(); pend.delete(); exp_rd.delete();
    mst = 0; drops = 0;
    drive(0, 8'h00, 0, 0, 0);
    RSTn = 1'b0;
    #2;
    if (check) chk_rst();
    @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  // One clock of stimulus; the queue model predicts the 16-deep DUT.
  task automatic step(input logic we, input logic [7:0] wd,
                      input logic cm, input logic dr, input logic re);
    int occ, lvl_pre, free_pre;
    bit fm, em, wacc, racc;
    occ = q_comm.size() + pend.size();
    fm = (occ == 16);
    em = (q_comm.size() == 0);
    wacc = we && !fm && (mst != 2);
    racc = re && !em;
    lvl_pre = q_comm.size();
    free_pre = 16 - occ;
    drive(we, wd, cm, dr, re);
    @(posedge CLK);
    if (racc) exp_rd.push_back(q_comm.pop_front());
    if (mst == 0) begin
      if (wacc) begin pend.push_back(wd); mst = 1; end
    end else if (mst == 1) begin
      if (dr) begin
        pend.delete(); mst = 0;
        if (drops < 255) drops++;
      end else if (cm) begin
        if (wacc) pend.push_back(wd);
        foreach (pend[i]) q_comm.push_back(pend[i]);
        pend.delete(); mst = 0;
      end else if (wacc) pend.push_back(wd);
      else if (we && fm && OVF_EN) mst = 2;
    end else if (dr || cm) begin
      pend.delete(); mst = 0;
      if (drops < 255) drops++;
    end
    #1;
    chk("rd_valid", ia.rd_valid, int'(racc));
    if (ia.rd_valid) begin
      if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_data", ia.rd_data, exp_rd.pop_front());
    end
    chk("empty", ia.empty, int'(q_comm.size() == 0));
    chk("full", ia.full, int'(q_comm.size() + pend.size() == 16));
    chk("busy", ia.busy, int'(mst != 0));
    chk("drop_cnt", ia.drop_cnt, drops);
    chk("level", ia.level, lvl_pre);
    chk("free", ia.free, free_pre);
  endtask

  initial begin
    tbl[0] = '{1, 8'h11, 0, 0, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{1, 8'h22, 0, 0, 0, 1, 0, 0, 8'h00};
    tbl[2] = '{1, 8'h33, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[3] = '{0, 8'h00, 0, 0, 0, 0, 3, 0, 8'h00};
    tbl[4] = '{0, 8'h00, 0, 0, 1, 0, 3, 1, 8'h11};
    tbl[5] = '{0, 8'h00, 0, 0, 1, 0, 2, 1, 8'h22};
    tbl[6] = '{0, 8'h00, 0, 0, 1, 1, 1, 1, 8'h33};
    tbl[7] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00};

    RSTn = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    #3;
    do_reset(1);

    // basic commit and read-back
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].cm, tbl[i].dr, tbl[i].re);
      chk($sformatf("v%0d_empty_a", i), ia.empty, tbl[i].e_empty);
      chk($sformatf("v%0d_empty_b", i), ib.empty, tbl[i].e_empty);
      chk($sformatf("v%0d_level_b", i), ib.level, tbl[i].e_level);
      chk($sformatf("v%0d_rdv_b", i), ib.rd_valid, tbl[i].e_rdv);
      if (tbl[i].e_rdv)
        chk($sformatf("v%0d_rd_b", i), ib.rd_data, tbl[i].e_rd);
    end

    // commit/drop while idle are ignored
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("idle_drop_b", ib.drop_cnt, 0);

    // dropped packet, then a good one
    for (int i = 0; i < 5; i++) step(1, 8'hB0 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("drop_wpcp_b", ib.free, 512);
    chk("drop_cnt_b", ib.drop_cnt, 1);
    chk("drop_empty_b", ib.empty, 1);
    step(1, 8'hA0, 0, 0, 0);
    step(1, 8'hA1, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    chk("a0_b", ib.rd_data, 8'hA0);
    step(0, 8'h00, 0, 0, 1);
    chk("a1_b", ib.rd_data, 8'hA1);

    // commit and drop together: drop wins
    step(1, 8'hC0, 0, 0, 0);
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("both_drop_b", ib.drop_cnt, 2);
    chk("both_empty_b", ib.empty, 1);
    chk("both_free_b", ib.free, 512);

    // fill the 16-deep instance
    do_reset(0);
    for (int i = 0; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("fill_full", ia.full, 1);
    chk("fill_level", ia.level, 16);
    step(1, 8'hEE, 0, 0, 0);
    chk("w17_busy", ia.busy, 0);
    chk("w17_free", ia.free, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 0, 0, 1);
    chk("drain_empty", ia.empty, 1);

    // overflowing packet
    for (int i = 0; i < 16; i++) step(1, 8'h60 + 8'(i), 0, 0, 0);
    step(1, 8'hEF, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
`ifdef RXPKT_OVF_DROP_EN
    chk("ovf_drop", ia.drop_cnt, 1);
    chk("ovf_empty", ia.empty, 1);
    chk("ovf_free", ia.free, 16);
`else
    chk("ovf_drop", ia.drop_cnt, 0);
    chk("ovf_level", ia.level, 16);
`endif
    for (int i = 0; i < 17; i++) step(0, 8'h00, 0, 0, 1);

    // 40 packets across pointer wrap with interleaved reads
    do_reset(0);
    for (int p = 0; p < 40; p++) begin
      for (int w = 0; w < 7; w++) begin
        step(1, 8'($urandom_range(0, 255)), 0, 0, 1);
        if (w == 2) begin
          step(0, 8'h00, 0, 0, 0);
          chk("sum_lvl_free", int'(ia.level) + int'(ia.free), 13);
        end
      end
      step(0, 8'h00, 1, 0, 1);
    end
    for (int i = 0; i < 12; i++) step(0, 8'h00, 0, 0, 1);
    chk("wrap_left", exp_rd.size(), 0);
    chk("wrap_empty", ia.empty, 1);

    // reset in the middle of a packet
    for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
    do_reset(1);
    step(0, 8'h00, 0, 0, 0);
    chk("post_rst_drop", ia.drop_cnt, 0);
    chk("post_rst_empty", ia.empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
